// File: rtl/ecc_error_monitor.sv
// ECC error monitor: registers decoded beats out with a poison flag, counts CE/UE events,
// captures the first error address and drives a health state machine with a level interrupt.
module ecc_error_monitor #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = 8,
    parameter int CE_THRESHOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_error_detected,
    input  logic                  in_error_corrected,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_poison,
    output logic [CNT_WIDTH-1:0]  ce_count,
    output logic [CNT_WIDTH-1:0]  ue_count,
    output logic                  first_err_valid,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  first_err_ue,
    output logic [1:0]            health,
    output logic                  irq,
    input  logic                  clear
);

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        DEGRADED = 2'b01,
        FAILED   = 2'b10
    } health_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CE_THR  = CNT_WIDTH'(CE_THRESHOLD);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_poison_q, out_poison_d;
    logic [CNT_WIDTH-1:0]  ce_q, ce_d, ue_q, ue_d;
    logic                  first_valid_q, first_valid_d;
    logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
    logic                  first_ue_q, first_ue_d;
    health_e               health_q, health_d;
    logic                  irq_q, irq_d;

    logic accept, is_ce, is_ue;

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    // The illegal det=0/corr=1 combination falls into UE together with det=1/corr=0.
    assign is_ce    = accept & in_error_detected & in_error_corrected;
    assign is_ue    = accept & (in_error_detected ^ in_error_corrected);

    // Clear forms the base state; an accepted event in the same cycle is applied on top of it.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_poison_d  = out_poison_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = in_data;
            out_poison_d = is_ue;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end

        ce_d          = clear ? '0 : ce_q;
        ue_d          = clear ? '0 : ue_q;
        first_valid_d = clear ? 1'b0 : first_valid_q;
        first_addr_d  = clear ? '0 : first_addr_q;
        first_ue_d    = clear ? 1'b0 : first_ue_q;
        health_d      = clear ? NORMAL : health_q;
        irq_d         = clear ? 1'b0 : irq_q;

        if (is_ce && ce_d != CNT_MAX) ce_d = ce_d + 1'b1;
        if (is_ue && ue_d != CNT_MAX) ue_d = ue_d + 1'b1;

        if ((is_ce || is_ue) && !first_valid_d) begin
            first_valid_d = 1'b1;
            first_addr_d  = in_addr;
            first_ue_d    = is_ue;
        end

        if (is_ue) begin
            if (health_d != FAILED) begin
                health_d = FAILED;
                irq_d    = 1'b1;
            end
        end else if (health_d == NORMAL && ce_d >= CE_THR) begin
            health_d = DEGRADED;
            irq_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_poison_q  <= 1'b0;
            ce_q          <= '0;
            ue_q          <= '0;
            first_valid_q <= 1'b0;
            first_addr_q  <= '0;
            first_ue_q    <= 1'b0;
            health_q      <= NORMAL;
            irq_q         <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_poison_q  <= out_poison_d;
            ce_q          <= ce_d;
            ue_q          <= ue_d;
            first_valid_q <= first_valid_d;
            first_addr_q  <= first_addr_d;
            first_ue_q    <= first_ue_d;
            health_q      <= health_d;
            irq_q         <= irq_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_poison      = out_poison_q;
    assign ce_count        = ce_q;
    assign ue_count        = ue_q;
    assign first_err_valid = first_valid_q;
    assign first_err_addr  = first_addr_q;
    assign first_err_ue    = first_ue_q;
    assign health          = health_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_ecc_error_monitor.sv
// Testbench for ecc_error_monitor: directed and random beats compared cycle by cycle
// against an integer-level model of the monitor's rules.
module tb_ecc_error_monitor;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int CW   = 8;
    localparam int THR  = 4;
    localparam int MAXC = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          in_error_detected, in_error_corrected;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          out_poison;
    logic [CW-1:0] ce_count, ue_count;
    logic          first_err_valid;
    logic [AW-1:0] first_err_addr;
    logic          first_err_ue;
    logic [1:0]    health;
    logic          irq;
    logic          clear;

    always #5 clk = ~clk;

    ecc_error_monitor #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .CE_THRESHOLD(THR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .in_error_detected(in_error_detected), .in_error_corrected(in_error_corrected),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_poison(out_poison),
        .ce_count(ce_count), .ue_count(ue_count),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr), .first_err_ue(first_err_ue),
        .health(health), .irq(irq), .clear(clear)
    );

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    // Reference model: health 0=NORMAL 1=DEGRADED 2=FAILED, counts as plain integers.
    int         mCe, mUe, mHealth;
    bit         mOutValid, mPoison, mFirstValid, mFirstUe, mIrq;
    logic [7:0] mData, mFirstAddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCe = 0; mUe = 0; mHealth = 0;
        mOutValid = 0; mPoison = 0; mFirstValid = 0; mFirstUe = 0; mIrq = 0;
        mData = '0; mFirstAddr = '0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mOutValid));
        check({tag, ".out_data"}, 32'(out_data), 32'(mData));
        check({tag, ".out_poison"}, 32'(out_poison), 32'(mPoison));
        check({tag, ".ce_count"}, 32'(ce_count), 32'(mCe));
        check({tag, ".ue_count"}, 32'(ue_count), 32'(mUe));
        check({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(mFirstValid));
        check({tag, ".first_err_addr"}, 32'(first_err_addr), 32'(mFirstAddr));
        check({tag, ".first_err_ue"}, 32'(first_err_ue), 32'(mFirstUe));
        check({tag, ".health"}, 32'(health), 32'(mHealth));
        check({tag, ".irq"}, 32'(irq), 32'(mIrq));
    endtask

    // Drives one cycle of inputs, checks in_ready before the edge and every output after it.
    task automatic applyStimulus(input string tag, input bit v, input logic [7:0] a,
                                 input logic [7:0] d, input bit det, input bit corr,
                                 input bit ordy, input bit clr);
        bit acc, isCe, isUe;
        in_valid = v; in_addr = a; in_data = d;
        in_error_detected = det; in_error_corrected = corr;
        out_ready = ordy; clear = clr;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!mOutValid || ordy));
        acc  = v && (!mOutValid || ordy);
        isCe = acc && det && corr;
        isUe = acc && (det || corr) && !(det && corr);
        @(posedge clk);
        #1;
        if (acc) begin
            mOutValid = 1; mData = d; mPoison = isUe;
        end else if (ordy) begin
            mOutValid = 0;
        end
        if (clr) begin
            mCe = 0; mUe = 0; mFirstValid = 0; mFirstAddr = '0; mFirstUe = 0;
            mHealth = 0; mIrq = 0;
        end
        if (isCe) mCe = (mCe + 1 > MAXC) ? MAXC : mCe + 1;
        if (isUe) mUe = (mUe + 1 > MAXC) ? MAXC : mUe + 1;
        if ((isCe || isUe) && !mFirstValid) begin
            mFirstValid = 1; mFirstAddr = a; mFirstUe = isUe;
        end
        if (isUe && mHealth != 2) begin
            mHealth = 2; mIrq = 1;
        end else if (!isUe && mHealth == 0 && mCe >= THR) begin
            mHealth = 1; mIrq = 1;
        end
        checkOutput(tag);
    endtask

    initial begin
        modelReset();
        rst_n = 1'b0;
        in_valid = 0; in_addr = '0; in_data = '0;
        in_error_detected = 0; in_error_corrected = 0;
        out_ready = 1; clear = 0;
        #12;
        checkOutput("reset");
        check("reset.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        $display("[TB] clean beats");
        for (int i = 0; i < 10; i++)
            applyStimulus("clean", 1, 8'($urandom), 8'($urandom), 0, 0, 1, 0);

        $display("[TB] CE beats to DEGRADED");
        for (int i = 0; i < 4; i++)
            applyStimulus("ce", 1, 8'(8'h10 + i), 8'($urandom), 1, 1, 1, 0);
        applyStimulus("ce_idle", 0, 8'h00, 8'h00, 0, 0, 1, 0);

        $display("[TB] UE then CE beats");
        applyStimulus("clr", 0, 8'h00, 8'h00, 0, 0, 1, 1);
        applyStimulus("ue", 1, 8'h2A, 8'($urandom), 1, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus("ue_ce", 1, 8'(8'h30 + i), 8'($urandom), 1, 1, 1, 0);

        $display("[TB] backpressure");
        applyStimulus("bp_load", 1, 8'h40, 8'hA5, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("bp_hold", 1, 8'h41, 8'h5A, 1, 1, 0, 0);
        applyStimulus("bp_release", 1, 8'h41, 8'h5A, 1, 1, 1, 0);

        $display("[TB] saturation and clear with CE");
        applyStimulus("clr2", 0, 8'h00, 8'h00, 0, 0, 1, 1);
        for (int i = 0; i < 260; i++)
            applyStimulus("sat", 1, 8'($urandom), 8'($urandom), 1, 1, 1, 0);
        applyStimulus("clr_ce", 1, 8'h77, 8'h3C, 1, 1, 1, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            int kind;
            bit det, corr;
            kind = int'($urandom_range(0, 9));
            det  = (kind >= 6);
            corr = (kind == 6 || kind == 7 || kind == 9);
            applyStimulus("rand", $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                          det, corr, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end

        $display("[TB] reset mid-stream");
        applyStimulus("pre_rst", 1, 8'h55, 8'hC3, 0, 0, 0, 0);
        applyStimulus("pre_rst2", 1, 8'h56, 8'h3C, 1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("mid_rst");
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        applyStimulus("illegal", 1, 8'h66, 8'h99, 0, 1, 1, 0);
        applyStimulus("post_idle", 0, 8'h00, 8'h00, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ecc_error_monitor.md
Name: ecc_error_monitor

Overview:
- Downstream stage of the system-level SECDED decoder.
- Accepts decoded data with its error flags over a valid/ready handshake and registers the data out with a poison flag.
- Classifies each beat as clean, correctable (CE) or uncorrectable (UE), keeps saturating error counters, captures the first error address, and drives a health state machine and an interrupt for the system controller.

Parameters:
- DATA_WIDTH, 8, width of decoded data word.
- ADDR_WIDTH, 8, width of the source address carried alongside each word.
- CNT_WIDTH, 8, width of the CE and UE counters.
- CE_THRESHOLD, 4, CE count at which health goes to DEGRADED; must be between 1 and 2^CNT_WIDTH-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  monitor can accept a beat.
- in_addr  input  ADDR_WIDTH  address of the decoded word.
- in_data  input  DATA_WIDTH  decoded data word.
- in_error_detected  input  1  decoder error_detected flag.
- in_error_corrected  input  1  decoder error_corrected flag.
- out_valid  output  1  registered beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  registered data.
- out_poison  output  1  beat is uncorrectable; data must not be consumed as good.
- ce_count  output  CNT_WIDTH  saturating correctable-error count.
- ue_count  output  CNT_WIDTH  saturating uncorrectable-error count.
- first_err_valid  output  1  first-error record holds a capture.
- first_err_addr  output  ADDR_WIDTH  address of the first CE or UE since reset/clear.
- first_err_ue  output  1  1 if the first captured error was UE.
- health  output  2  00 NORMAL, 01 DEGRADED, 10 FAILED.
- irq  output  1  level interrupt.
- clear  input  1  synchronous one-cycle clear of counters, capture, health and irq.

Behaviour:
- Interface: one clock domain on clk; rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_poison=0, ce_count=0, ue_count=0, first_err_valid=0, first_err_addr=0, first_err_ue=0, health=NORMAL, irq=0. in_ready reads 1 after reset.

Handshake:
- Single output register. in_ready = !out_valid | out_ready (combinational).
- Accept = in_valid & in_ready. On accept, out_data and out_poison load on the next edge and out_valid=1.
- Latency is 1 cycle; throughput is 1 beat/cycle with continuous out_ready.
- If out_valid & !out_ready, out_* hold stable and in_ready=0.
- If there is no accept and out_ready=1, out_valid clears.

Classification (accepted beats only):
- det=0, corr=0 -> clean.
- det=1, corr=1 -> CE.
- det=1, corr=0 -> UE.
- det=0, corr=1 is an illegal combination and is treated as UE.
- out_poison = UE.

Counters:
- ce_count increments on each accepted CE; ue_count increments on each accepted UE.
- Both saturate at 2^CNT_WIDTH-1; no wrap.

First-error capture:
- On the first accepted CE or UE while first_err_valid=0, load first_err_addr and first_err_ue and set first_err_valid.
- The record is frozen until clear.

Health FSM (next state computed from post-update counts):
- NORMAL -> DEGRADED when ce_count reaches CE_THRESHOLD.
- NORMAL or DEGRADED -> FAILED on any accepted UE.
- FAILED is sticky. DEGRADED never returns to NORMAL except on clear. UE takes priority over CE.

irq:
- Set on the cycle after any health transition.
- Stays high until clear.

clear:
- Zeroes counters, capture, health (to NORMAL) and irq. Does not affect the data path.
- If clear and an accept coincide, the cleared state is the base and the accepted event then applies. Example: CE with clear gives ce_count=1 and a first-error capture of that beat.

Reset mid-transfer:
- A pending out beat is dropped (out_valid=0).

Test Plan:
- Reset, then 10 clean beats with out_ready=1 -> data out 1 cycle later, identical; out_poison=0; counts 0; health NORMAL; irq 0.
- CE beats at addr 0x10, 0x11, 0x12, 0x13 -> ce_count 1..4; first_err_addr=0x10, first_err_ue=0; health DEGRADED after the 4th; irq=1 the next cycle.
- UE at addr 0x2A, then CE beats -> out_poison=1 on that beat; ue_count=1; health FAILED and remains FAILED; first_err_addr=0x2A, first_err_ue=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; out_data stable; no beat lost or duplicated; counters update exactly once per accepted beat.
- 260 CE beats with CNT_WIDTH=8 -> ce_count saturates at 255. Then clear concurrent with a CE -> ce_count=1, health NORMAL, irq=0, first-error capture holds that beat.
- Assert rst_n low mid-stream with out_valid=1 -> all outputs return to reset values immediately; det=0, corr=1 input afterwards counts as UE.
